// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the default queue-entry layout for the
// instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int XLEN_DEF = 32;
  localparam int PC_STEP  = 4;

  // One buffered fetch: the instruction word tagged with its PC.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO with registered occupancy and a
// single-cycle flush. DEPTH must be a power of two so the pointers wrap
// naturally.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction-fetch front end. Keeps at most one
// memory request in flight, buffers responses with their PCs in a queue and
// hands them to decode over valid/ready. A redirect flushes the queue and
// marks any still-pending response to be discarded.
// Optional build macro FETCH_PERF_EN adds pop/flush event counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_pcplus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = XLEN + INSTR_W;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic            outstanding;
  logic            drop;
  logic [CW-1:0]   occ;
  logic [EW-1:0]   head;
  logic            room;
  logic            accept;
  logic            resp;
  logic            push;
  logic            pop;

  // Room check uses the registered count: a same-cycle pop frees nothing,
  // and an outstanding request still reserves a slot in its response cycle.
  assign room      = (32'(occ) + 32'(outstanding)) < 32'(QDEPTH);
  assign imem_req  = rst_n & ~redirect & (~outstanding | imem_rvalid) & room;
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready;
  assign resp      = imem_rvalid & outstanding;
  assign push      = resp & ~drop & ~redirect;
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready & ~redirect;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // Program counter and the PC of the request currently in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
    end else begin
      if (redirect)    pc <= redirect_aligned;
      else if (accept) pc <= pc + XLEN'(PC_STEP);
      if (accept) pend_pc <= pc;
    end
  end

  // Single-outstanding tracking; drop marks a response orphaned by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (accept)    outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;
      if (redirect && outstanding && !imem_rvalid) drop <= 1'b1;
      else if (resp)                               drop <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (EW)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data ({pend_pc, imem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (occ)
  );

  assign out_pc      = head[EW-1:INSTR_W];
  assign out_instr   = head[INSTR_W-1:0];
  assign out_pcplus4 = out_pc + XLEN'(PC_STEP);

`ifdef FETCH_PERF_EN
  // Event counters: pops, and everything a redirect throws away (queued
  // entries plus an in-flight response not already marked for dropping).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop)      perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushed <= perf_flushed + 32'(occ) + 32'(outstanding & ~drop);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a behavioural
// instruction memory of programmable latency.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_snap;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic [31:0] exp_pc = 32'h0;
  int          found;
  int          snap;

  int          mem_cyc      = 0;
  int          mem_due      = 0;
  int          mem_lat      = 1;
  int          mem_resp_cnt = 0;
  bit          mem_pend     = 1'b0;
  bit          mem_resp     = 1'b0;
  logic [31:0] mem_addr     = 32'h0;

  fetch_stage #(
    .XLEN     (32),
    .QDEPTH   (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pcplus4  (out_pcplus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    if (out_valid && out_ready && !redirect) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_instr", out_instr, mem_word(exp_pc));
      chk("out_pcplus4", out_pcplus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
  endtask

  task automatic half();
    @(negedge clk);
    #1;
    pop_check();
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: one response per accepted request, mem_lat cycles
  // later; also flags any acceptance while a response is still owed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_cyc++;
      mem_resp    = mem_pend && (mem_due == mem_cyc);
      imem_rvalid = mem_resp;
      imem_rdata  = mem_resp ? mem_word(mem_addr) : 32'hDEAD_BEEF;
      @(negedge clk);
      if (mem_resp) begin
        mem_pend = 1'b0;
        mem_resp_cnt++;
      end
      if (!rst_n) begin
        mem_pend = 1'b0;
      end else if (imem_req && imem_ready) begin
        chk("single_outstanding", {31'h0, mem_pend}, 32'h0);
        mem_pend = 1'b1;
        mem_addr = imem_addr;
        mem_due  = mem_cyc + mem_lat;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b1;
    imem_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    half();
    chk("rst_req", imem_req, 32'h0);
    chk("rst_valid", out_valid, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
    fin();

    // Streaming with a 1-cycle memory
    rst_n = 1'b1;
    half();
    chk("first_req", imem_req, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    fin();
    for (int i = 1; i < 14; i++) begin
      half();
      if (i >= 2) chk("tput_valid", out_valid, 32'h1);
      fin();
    end

    // Back-pressure: queue fills to exactly four entries
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      half();
      fin();
    end
    half();
    chk("full_req", imem_req, 32'h0);
    chk("full_addr", imem_addr, exp_pc + 32'd16);
    chk("full_valid", out_valid, 32'h1);
    chk("full_head", out_pc, exp_pc);
    fin();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      half();
      fin();
    end

    // 3-cycle memory latency
    mem_lat = 3;
    for (int i = 0; i < 20; i++) begin
      half();
      fin();
    end

    // Redirect near the top of the address space, 1-cycle memory
    mem_lat = 1;
    for (int i = 0; i < 8; i++) begin
      half();
      fin();
    end
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_pc      = 32'hFFFF_FFF8;
    half();
    fin();
    redirect = 1'b0;
    half();
    chk("r1_valid", out_valid, 32'h0);
    chk("r1_req", imem_req, 32'h1);
    chk("r1_addr", imem_addr, 32'hFFFF_FFF8);
    fin();
    half();
    chk("r2_valid", out_valid, 32'h0);
    fin();
    half();
    chk("r3_valid", out_valid, 32'h1);
    fin();
    for (int i = 0; i < 5; i++) begin
      half();
      fin();
    end
    chk("wrap_progress", exp_pc, 32'h0000_0010);

    // Redirect while a request is outstanding; stale response must drop
    mem_lat = 3;
    found   = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      half();
      if (mem_pend && mem_due > mem_cyc + 2) found = 1;
      fin();
    end
    chk("find_outstanding", found, 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    out_ready   = 1'b0;
    snap        = mem_resp_cnt;
    half();
    fin();
    redirect = 1'b0;
    half();
    chk("a1_valid", out_valid, 32'h0);
    chk("a1_req", imem_req, 32'h0);
    fin();
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      half();
      if (mem_resp_cnt >= snap + 4) found = 1;
      fin();
    end
    chk("a_resp_wait", found, 32'h1);
    half();
    chk("a_head_valid", out_valid, 32'h1);
    chk("a_head_pc", out_pc, 32'h0000_0100);
    chk("a_head_instr", out_instr, mem_word(32'h0000_0100));
    chk("a_full_req", imem_req, 32'h0);
`ifdef FETCH_PERF_EN
    perf_snap = perf_flushed;
`endif
    fin();

    // Second redirect: three queued entries plus one in-flight response
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    exp_pc      = 32'h0000_0200;
    out_ready   = 1'b1;
    half();
    fin();
    redirect = 1'b0;
    half();
    chk("b1_valid", out_valid, 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_flushed_delta", perf_flushed - perf_snap, 32'd4);
`endif
    fin();
    for (int i = 0; i < 20; i++) begin
      half();
      fin();
    end
    chk("b_progress", {31'h0, (exp_pc >= 32'h0000_0210)}, 32'h1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(n_pops));
`endif

    // Reset in mid-operation
    rst_n = 1'b0;
    half();
    chk("rst2_req", imem_req, 32'h0);
    chk("rst2_valid", out_valid, 32'h0);
    chk("rst2_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst2_perf_fetched", perf_fetched, 32'h0);
    chk("rst2_perf_flushed", perf_flushed, 32'h0);
`endif
    fin();
    rst_n   = 1'b1;
    exp_pc  = 32'h0;
    n_pops  = 0;
    mem_lat = 1;
    half();
    chk("rst2_first_req", imem_req, 32'h1);
    fin();
    for (int i = 1; i < 11; i++) begin
      half();
      if (i >= 2) chk("rst2_tput_valid", out_valid, 32'h1);
      fin();
    end
    chk("rst2_progress", exp_pc, 32'h0000_0024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
